// File: rtl/spm_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spm_control_unit                                              |
// | Purpose  : Fetch/decode/execute sequencer for the stored-program machine.|
// |            Optional macro CU_ILLEGAL_HALT_EN halts on opcodes 9-E.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module spm_control_unit #(
  parameter int word_size = 8,
  parameter int op_size   = 4,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 zero,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  output logic                 write,
  output logic                 halted
);

  typedef enum logic [3:0] {
    S_idle = 4'd0,
    S_fet1 = 4'd1,
    S_fet2 = 4'd2,
    S_dec  = 4'd3,
    S_ex1  = 4'd4,
    S_rd1  = 4'd5,
    S_rd2  = 4'd6,
    S_wr1  = 4'd7,
    S_wr2  = 4'd8,
    S_br1  = 4'd9,
    S_br2  = 4'd10,
    S_halt = 4'd11
  } state_t;

  localparam logic [op_size-1:0] c_NOP  = op_size'(0);
  localparam logic [op_size-1:0] c_ADD  = op_size'(1);
  localparam logic [op_size-1:0] c_SUB  = op_size'(2);
  localparam logic [op_size-1:0] c_AND  = op_size'(3);
  localparam logic [op_size-1:0] c_NOT  = op_size'(4);
  localparam logic [op_size-1:0] c_RD   = op_size'(5);
  localparam logic [op_size-1:0] c_WR   = op_size'(6);
  localparam logic [op_size-1:0] c_BR   = op_size'(7);
  localparam logic [op_size-1:0] c_BRZ  = op_size'(8);
  localparam logic [op_size-1:0] c_HALT = op_size'(15);

  localparam logic [Sel1_size-1:0] c_SEL1_PC   = Sel1_size'(4);
  localparam logic [Sel2_size-1:0] c_SEL2_ALU  = Sel2_size'(0);
  localparam logic [Sel2_size-1:0] c_SEL2_BUS1 = Sel2_size'(1);
  localparam logic [Sel2_size-1:0] c_SEL2_MEM  = Sel2_size'(2);

  state_t               r_state;
  state_t               w_next;
  logic [op_size-1:0]   w_opcode;
  logic [1:0]           w_src;
  logic [1:0]           w_dest;
  logic [3:0]           w_load_r;

  assign w_opcode = instruction[word_size-1 -: op_size];
  assign w_src    = instruction[3:2];
  assign w_dest   = instruction[1:0];

  assign Load_R0 = w_load_r[0];
  assign Load_R1 = w_load_r[1];
  assign Load_R2 = w_load_r[2];
  assign Load_R3 = w_load_r[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = S_idle;
    w_load_r      = 4'b0000;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    Sel_Bus_1_Mux = '0;
    Sel_Bus_2_Mux = '0;
    write         = 1'b0;
    halted        = 1'b0;

    case (r_state)
      S_idle: w_next = S_fet1;

      S_fet1: begin
        Sel_Bus_1_Mux = c_SEL1_PC;
        Sel_Bus_2_Mux = c_SEL2_BUS1;
        Load_Add_R    = 1'b1;
        w_next        = S_fet2;
      end

      S_fet2: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        Load_IR       = 1'b1;
        Inc_PC        = 1'b1;
        w_next        = S_dec;
      end

      S_dec: begin
        case (w_opcode)
          c_NOP: w_next = S_fet1;
          c_ADD, c_SUB, c_AND: begin
            Sel_Bus_1_Mux = Sel1_size'(w_src);
            Sel_Bus_2_Mux = c_SEL2_BUS1;
            Load_Reg_Y    = 1'b1;
            w_next        = S_ex1;
          end
          c_NOT: begin
            Sel_Bus_1_Mux    = Sel1_size'(w_src);
            Sel_Bus_2_Mux    = c_SEL2_ALU;
            Load_Reg_Z       = 1'b1;
            w_load_r[w_dest] = 1'b1;
            w_next           = S_fet1;
          end
          // RD/WR/BR all start by pointing Add_R at the operand word
          c_RD, c_WR, c_BR: begin
            Sel_Bus_1_Mux = c_SEL1_PC;
            Sel_Bus_2_Mux = c_SEL2_BUS1;
            Load_Add_R    = 1'b1;
            w_next        = (w_opcode == c_RD) ? S_rd1 :
                            (w_opcode == c_WR) ? S_wr1 : S_br1;
          end
          c_BRZ: begin
            if (zero) begin
              Sel_Bus_1_Mux = c_SEL1_PC;
              Sel_Bus_2_Mux = c_SEL2_BUS1;
              Load_Add_R    = 1'b1;
              w_next        = S_br1;
            end else begin
              Inc_PC = 1'b1;
              w_next = S_fet1;
            end
          end
          c_HALT: w_next = S_halt;
          default: begin
`ifdef CU_ILLEGAL_HALT_EN
            w_next = S_halt;
`else
            w_next = S_fet1;
`endif
          end
        endcase
      end

      S_ex1: begin
        Sel_Bus_1_Mux    = Sel1_size'(w_dest);
        Sel_Bus_2_Mux    = c_SEL2_ALU;
        Load_Reg_Z       = 1'b1;
        w_load_r[w_dest] = 1'b1;
        w_next           = S_fet1;
      end

      S_rd1: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        w_next        = S_rd2;
      end

      S_rd2: begin
        Sel_Bus_2_Mux    = c_SEL2_MEM;
        w_load_r[w_dest] = 1'b1;
        w_next           = S_fet1;
      end

      S_wr1: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        w_next        = S_wr2;
      end

      S_wr2: begin
        Sel_Bus_1_Mux = Sel1_size'(w_src);
        write         = 1'b1;
        w_next        = S_fet1;
      end

      S_br1: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        Load_Add_R    = 1'b1;
        w_next        = S_br2;
      end

      S_br2: begin
        Sel_Bus_2_Mux = c_SEL2_MEM;
        Load_PC       = 1'b1;
        w_next        = S_fet1;
      end

      S_halt: begin
        halted = 1'b1;
        w_next = S_halt;
      end

      default: w_next = S_idle;
    endcase
  end

endmodule
`default_nettype wire
